key_search_dispatcher: RTL and testbench

KEY_SEARCH_DISPATCHER -- requirements
Module: key_search_dispatcher

---
 rtl/key_search_pkg.sv | 22 ++
 rtl/core_status_latch.sv | 52 +++++
 rtl/key_search_dispatcher.sv | 157 +++++++++++++++
 tb/tb_key_search_dispatcher.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_pkg.sv
// Shared types and defaults for the RC4 key-search dispatcher.
// The elapsed-cycle timer is built only when DISPATCH_TIMER_EN is defined.
package key_search_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_RST_PULSE = 2;
    localparam int ELAPSED_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CORE_RST  = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4
    } dispatch_state_e;

    // A single core still needs a one-bit winner index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_status_latch.sv
// Sticky per-core failure mask plus lowest-index priority encoder for
// successes that are still honoured (core not yet marked failed).
module core_status_latch
    import key_search_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int IDX_W     = idx_width(DEF_NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [NUM_CORES-1:0] core_success,
    input  logic [NUM_CORES-1:0] core_failure,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 all_failed
);

    logic [NUM_CORES-1:0] fail_mask_r;
    logic [NUM_CORES-1:0] honoured_s;
    logic [IDX_W-1:0]     hit_idx_s;

    // Failure flags accumulate while searching and are wiped at search start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_mask_r <= {NUM_CORES{1'b0}};
        end else if (clear) begin
            fail_mask_r <= {NUM_CORES{1'b0}};
        end else if (enable) begin
            fail_mask_r <= fail_mask_r | core_failure;
        end else begin
            fail_mask_r <= fail_mask_r;
        end
    end

    // Same-cycle failures do not veto a success; only previously latched ones do.
    assign honoured_s = core_success & ~fail_mask_r;

    // Scan from the top down so the lowest honoured index wins.
    always_comb begin
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            hit_idx_s = honoured_s[i] ? IDX_W'(i) : hit_idx_s;
        end
    end

    assign hit        = |honoured_s;
    assign hit_idx    = hit_idx_s;
    assign all_failed = &(fail_mask_r | core_failure);

endmodule

// File: rtl/key_search_dispatcher.sv
// Supervises NUM_CORES parallel RC4 key-search cores: pulses their reset,
// watches success/failure flags, and reports winner or exhaustion.
// Optional elapsed-cycle timer is built when DISPATCH_TIMER_EN is defined.
module key_search_dispatcher
    import key_search_pkg::*;
#(
    parameter int  NUM_CORES = DEF_NUM_CORES,
    parameter int  RST_PULSE = DEF_RST_PULSE,
    localparam int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_success,
    input  logic [NUM_CORES-1:0] core_failure,
    output logic                 core_reset_n,
    output logic                 core_stop,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [IDX_W-1:0]     winner_idx,
    output logic [31:0]          elapsed_cycles
);

    localparam logic [3:0] PULSE_LAST = 4'(RST_PULSE - 1);

    dispatch_state_e  state_r;
    dispatch_state_e  next_s;
    logic [3:0]       pulse_cnt_r;
    logic [IDX_W-1:0] winner_r;
    logic             core_reset_n_r;
    logic             core_stop_r;
    logic             busy_r;
    logic             found_r;
    logic             exhausted_r;
    logic             in_search_s;
    logic             enter_rst_s;
    logic             hit_s;
    logic [IDX_W-1:0] hit_idx_s;
    logic             all_failed_s;

    assign in_search_s = (state_r == ST_SEARCH);
    assign enter_rst_s = (next_s == ST_CORE_RST) && (state_r != ST_CORE_RST);

    core_status_latch #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_status (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (enter_rst_s),
        .enable       (in_search_s),
        .core_success (core_success),
        .core_failure (core_failure),
        .hit          (hit_s),
        .hit_idx      (hit_idx_s),
        .all_failed   (all_failed_s)
    );

    // Next-state decode; success takes precedence over a final failure.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_s = ST_CORE_RST;
                else       next_s = state_r;
            end
            ST_CORE_RST: begin
                if (pulse_cnt_r == PULSE_LAST) next_s = ST_SEARCH;
                else                           next_s = state_r;
            end
            ST_SEARCH: begin
                if (hit_s)             next_s = ST_FOUND;
                else if (all_failed_s) next_s = ST_EXHAUSTED;
                else                   next_s = state_r;
            end
            ST_FOUND, ST_EXHAUSTED: begin
                if (start) next_s = ST_CORE_RST;
                else       next_s = state_r;
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // State register with outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            core_reset_n_r <= 1'b0;
            core_stop_r    <= 1'b0;
            busy_r         <= 1'b0;
            found_r        <= 1'b0;
            exhausted_r    <= 1'b0;
        end else begin
            state_r        <= next_s;
            core_reset_n_r <= (next_s == ST_SEARCH) || (next_s == ST_FOUND) ||
                              (next_s == ST_EXHAUSTED);
            core_stop_r    <= (next_s == ST_FOUND) || (next_s == ST_EXHAUSTED);
            busy_r         <= (next_s == ST_CORE_RST) || (next_s == ST_SEARCH);
            found_r        <= (next_s == ST_FOUND);
            exhausted_r    <= (next_s == ST_EXHAUSTED);
        end
    end

    // Counts cycles spent in CORE_RST to size the core reset pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt_r <= 4'd0;
        end else if ((state_r == ST_CORE_RST) && (next_s == ST_CORE_RST)) begin
            pulse_cnt_r <= pulse_cnt_r + 4'd1;
        end else begin
            pulse_cnt_r <= 4'd0;
        end
    end

    // Winner index captured on the success cycle, cleared when a run starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winner_r <= {IDX_W{1'b0}};
        end else if (enter_rst_s) begin
            winner_r <= {IDX_W{1'b0}};
        end else if (in_search_s && hit_s) begin
            winner_r <= hit_idx_s;
        end else begin
            winner_r <= winner_r;
        end
    end

`ifdef DISPATCH_TIMER_EN
    logic [ELAPSED_W-1:0] elapsed_r;

    // Saturating count of SEARCH cycles, frozen elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elapsed_r <= {ELAPSED_W{1'b0}};
        end else if (enter_rst_s) begin
            elapsed_r <= {ELAPSED_W{1'b0}};
        end else if (in_search_s && (elapsed_r != 32'hFFFF_FFFF)) begin
            elapsed_r <= elapsed_r + 32'd1;
        end else begin
            elapsed_r <= elapsed_r;
        end
    end

    assign elapsed_cycles = elapsed_r;
`else
    assign elapsed_cycles = 32'd0;
`endif

    assign core_reset_n = core_reset_n_r;
    assign core_stop    = core_stop_r;
    assign busy         = busy_r;
    assign found        = found_r;
    assign exhausted    = exhausted_r;
    assign winner_idx   = winner_r;

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Scoreboard bench for key_search_dispatcher (NUM_CORES=4, RST_PULSE=2).
// Expects elapsed_cycles activity only when DISPATCH_TIMER_EN is defined.
module tb_key_search_dispatcher;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  core_success;
    logic [3:0]  core_failure;
    logic        core_reset_n;
    logic        core_stop;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [1:0]  winner_idx;
    logic [31:0] elapsed_cycles;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       found;
        logic       exhausted;
        logic [1:0] winner;
    } exp_t;

    exp_t sb[$];

    key_search_dispatcher #(.NUM_CORES(4), .RST_PULSE(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .core_success   (core_success),
        .core_failure   (core_failure),
        .core_reset_n   (core_reset_n),
        .core_stop      (core_stop),
        .busy           (busy),
        .found          (found),
        .exhausted      (exhausted),
        .winner_idx     (winner_idx),
        .elapsed_cycles (elapsed_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_search();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; core_success = 4'd0; core_failure = 4'd0;
        #12;
        vectors++;
        if ({core_reset_n, core_stop, busy, found, exhausted, winner_idx, elapsed_cycles} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got crn=%b stop=%b busy=%b found=%b exh=%b win=%0d el=%0d want all 0",
                     core_reset_n, core_stop, busy, found, exhausted, winner_idx, elapsed_cycles);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({core_reset_n, busy, found, exhausted} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_idle: got crn=%b busy=%b found=%b exh=%b want 0000",
                     core_reset_n, busy, found, exhausted);
        end
    endtask

    task automatic test_start();
        logic [1:0] exp_crn [3];
        exp_crn[0] = 2'b01; exp_crn[1] = 2'b01; exp_crn[2] = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({core_reset_n, busy} !== exp_crn[k]) begin
                miscompares++;
                $display("FAIL start_pulse_c%0d: got crn,busy=%b%b want %b", k, core_reset_n, busy, exp_crn[k]);
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_found();
        int c;
        exp_t e;
        core_success = 4'b1010;
        sb.push_back('{1'b1, 1'b0, 2'd1});
        tick();
        core_success = 4'd0;
        c = 0;
        while (!(found || exhausted) && c < 8) begin tick(); c++; end
        e = sb.pop_front();
        vectors++;
        if ({found, exhausted, winner_idx, core_stop, busy} !== {e.found, e.exhausted, e.winner, 1'b1, 1'b0} || c != 0) begin
            miscompares++;
            $display("FAIL found_1010: got f=%b x=%b w=%0d stop=%b busy=%b lat=%0d want f=%b x=%b w=%0d stop=1 busy=0 lat=0",
                     found, exhausted, winner_idx, core_stop, busy, c, e.found, e.exhausted, e.winner);
        end
    endtask

    task automatic test_exhaust();
        int c;
        exp_t e;
        start_search();
        vectors++;
        if ({found, winner_idx, busy} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rerun_clear: got f=%b w=%0d busy=%b want f=0 w=0 busy=1", found, winner_idx, busy);
        end
        for (int k = 0; k <= 9; k++) begin
            core_failure = (k == 3) ? 4'b0001 : (k == 5) ? 4'b0010 :
                           (k == 7) ? 4'b0100 : (k == 9) ? 4'b1000 : 4'b0000;
            if (k == 9) sb.push_back('{1'b0, 1'b1, 2'd0});
            tick();
            if (k == 8) begin
                vectors++;
                if ({exhausted, busy} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL exhaust_early: got exh=%b busy=%b want 0 1", exhausted, busy);
                end
            end
        end
        core_failure = 4'd0;
        c = 0;
        while (!(found || exhausted) && c < 8) begin tick(); c++; end
        e = sb.pop_front();
        vectors++;
        if ({found, exhausted, core_stop} !== {e.found, e.exhausted, 1'b1} || c != 0) begin
            miscompares++;
            $display("FAIL exhaust_4th: got f=%b x=%b stop=%b lat=%0d want f=%b x=%b stop=1 lat=0",
                     found, exhausted, core_stop, c, e.found, e.exhausted);
        end
        core_success = 4'b1111;
        tick();
        tick();
        core_success = 4'd0;
        vectors++;
        if ({found, exhausted, core_reset_n} !== 3'b011) begin
            miscompares++;
            $display("FAIL exhaust_hold: got f=%b x=%b crn=%b want 0 1 1", found, exhausted, core_reset_n);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        exp_t e;
        start_search();
        core_failure = 4'b0111;
        tick();
        core_failure = 4'b1000;
        core_success = 4'b1000;
        sb.push_back('{1'b1, 1'b0, 2'd3});
        tick();
        core_failure = 4'd0;
        core_success = 4'd0;
        c = 0;
        while (!(found || exhausted) && c < 8) begin tick(); c++; end
        e = sb.pop_front();
        vectors++;
        if ({found, exhausted, winner_idx} !== {e.found, e.exhausted, e.winner} || c != 0) begin
            miscompares++;
            $display("FAIL simul_succ_fail: got f=%b x=%b w=%0d lat=%0d want f=%b x=%b w=%0d lat=0",
                     found, exhausted, winner_idx, c, e.found, e.exhausted, e.winner);
        end
    endtask

    task automatic test_ignored();
        int c;
        exp_t e;
        start_search();
        core_failure = 4'b0001;
        tick();
        core_failure = 4'd0;
        core_success = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            tick();
            vectors++;
            if ({busy, core_reset_n, found, exhausted} !== 4'b1100) begin
                miscompares++;
                $display("FAIL masked_success_c%0d: got busy=%b crn=%b f=%b x=%b want 1 1 0 0",
                         k, busy, core_reset_n, found, exhausted);
            end
        end
        start = 1'b0;
        core_success = 4'b0011;
        sb.push_back('{1'b1, 1'b0, 2'd1});
        tick();
        core_success = 4'd0;
        c = 0;
        while (!(found || exhausted) && c < 8) begin tick(); c++; end
        e = sb.pop_front();
        vectors++;
        if ({found, exhausted, winner_idx} !== {e.found, e.exhausted, e.winner} || c != 0) begin
            miscompares++;
            $display("FAIL masked_lowest: got f=%b x=%b w=%0d lat=%0d want f=%b x=%b w=%0d lat=0",
                     found, exhausted, winner_idx, c, e.found, e.exhausted, e.winner);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_el;
        start_search();
        repeat (50) tick();
`ifdef DISPATCH_TIMER_EN
        exp_el = 32'd50;
`else
        exp_el = 32'd0;
`endif
        vectors++;
        if (elapsed_cycles !== exp_el || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL elapsed_50: got el=%0d busy=%b want el=%0d busy=1", elapsed_cycles, busy, exp_el);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({core_reset_n, core_stop, busy, found, exhausted, winner_idx, elapsed_cycles} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got crn=%b stop=%b busy=%b f=%b x=%b w=%0d el=%0d want all 0",
                     core_reset_n, core_stop, busy, found, exhausted, winner_idx, elapsed_cycles);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({core_reset_n, busy, found, exhausted, elapsed_cycles} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_no_resume: got crn=%b busy=%b f=%b x=%b el=%0d want all 0",
                     core_reset_n, busy, found, exhausted, elapsed_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_found();
        test_exhaust();
        test_simultaneous();
        test_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
